// File: rtl/uart_rx_if.sv
// Receiver output bundle: received byte, result strobes, status and FSM debug state.
// valid and frame_err are one-cycle strobes with no ready/backpressure; the consumer must take data the cycle valid is high.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic [2:0] dbg_state;

    modport master (output data, valid, frame_err, busy, dbg_state);
    modport slave  (input  data, valid, frame_err, busy, dbg_state);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line, runtime bit period in clock cycles.
// Frames are sampled mid-bit from the start-bit edge; a low stop bit flags frame_err and waits for the line to go high.
module uart_rx #(
    parameter int CFG_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic [CFG_W-1:0] clks_per_bit,
    uart_rx_if.master        port
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;

    state_t           state_q, state_d;
    logic [CFG_W-1:0] cnt_q, cnt_d;
    logic [CFG_W-1:0] cpb_q, cpb_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    logic [CFG_W-1:0] cpb_clamped;
    logic [CFG_W-1:0] half_m1;
    logic [CFG_W-1:0] full_m1;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
    assign rs = sync_q[SYNC_STAGES-1];

    // Periods below 4 leave no room for a mid-bit sample, so they are clamped.
    assign cpb_clamped = (clks_per_bit < CFG_W'(4)) ? CFG_W'(4) : clks_per_bit;
    assign half_m1     = (cpb_q >> 1) - CFG_W'(1);
    assign full_m1     = cpb_q - CFG_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cpb_q   <= CFG_W'(4);
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cpb_q   <= cpb_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cpb_d   = cpb_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rs) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    cpb_d   = cpb_clamped;
                end
            end
            S_START: begin
                if (cnt_q == half_m1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rs ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CFG_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == full_m1) begin
                    sh_d  = {rs, sh_q[7:1]};
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CFG_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == full_m1) begin
                    cnt_d = '0;
                    if (rs) begin
                        valid_d = 1'b1;
                        data_d  = sh_q;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CFG_W'(1);
                end
            end
            S_BREAK: begin
                if (rs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign port.data      = data_q;
    assign port.valid     = valid_q;
    assign port.frame_err = ferr_q;
    assign port.busy      = (state_q != S_IDLE);
    assign port.dbg_state = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frame driver, expected-event queue model and per-cycle output compare.
module tb_uart_rx;
    localparam int CFG_W = 32;
    localparam int SYNC  = 2;
    localparam int W     = 41;  // {is_ferr, byte, due_cycle}

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx  = 1'b1;
    logic [CFG_W-1:0] clks_per_bit = 32'd100;

    uart_rx_if bus ();

    uart_rx #(.CFG_W(CFG_W), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .clks_per_bit (clks_per_bit),
        .port         (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_seen = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    logic [7:0]   model_data = 8'h00;
    int           last_valid_cyc = 0;
    int           checks = 0;
    int           errors = 0;
    bit           chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // compare process: every cycle after reset
    always @(negedge clk) begin
        if (chk_en) begin
            logic [W-1:0] e;
            int           due;
            if (rst_seen) model_data = 8'h00;
            chk("strobe_exclusive", {31'd0, bus.valid & bus.frame_err}, 32'd0);
            if (bus.valid || bus.frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {30'd0, bus.valid, bus.frame_err}, 32'd0);
                end else begin
                    e   = exp_q.pop_front();
                    due = int'(e[31:0]);
                    chk("event_kind", {31'd0, bus.frame_err}, {31'd0, e[40]});
                    checks++;
                    if (cyc < due - 1 || cyc > due + 1) begin
                        errors++;
                        $display("FAIL latency: got cycle %0d expected %0d +/-1", cyc, due);
                    end
                    if (bus.valid) begin
                        chk("valid_data", {24'd0, bus.data}, {24'd0, e[39:32]});
                        model_data     = e[39:32];
                        last_valid_cyc = cyc;
                    end
                end
            end
            chk("data_hold", {24'd0, bus.data}, {24'd0, model_data});
        end
    end

    // driver tasks (called at a negedge, return at a negedge)
    task automatic send_frame(input logic [7:0] b, input int cfg, input bit stop_ok, input bit perturb);
        int bt;
        int due;
        bt  = (cfg < 4) ? 4 : cfg;
        due = cyc + SYNC + 1 + 9 * bt + bt / 2;
        clks_per_bit = cfg;
        rx = 1'b0;
        exp_q.push_back({~stop_ok, b, due[31:0]});
        repeat (bt) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (perturb && i == 1) clks_per_bit = $urandom_range(1, 300);
            repeat (bt) @(negedge clk);
        end
        rx = stop_ok;
        repeat (bt) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int fall;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_data", {24'd0, bus.data}, 32'h0);
        chk("reset_valid", {31'd0, bus.valid}, 32'd0);
        chk("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk_en = 1'b1;
        idle(5);

        // 1: single frame, latency pinned by hand (3 + 900 + 50)
        fall = cyc;
        send_frame(8'hCA, 100, 1'b1, 1'b0);
        idle(20);
        chk("t1_data", {24'd0, bus.data}, 32'hCA);
        checks++;
        if (last_valid_cyc - fall < 952 || last_valid_cyc - fall > 954) begin
            errors++;
            $display("FAIL t1_latency: got %0d expected 952..954", last_valid_cyc - fall);
        end

        // 2: short low glitch is rejected
        clks_per_bit = 100;
        fall = cyc;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_busy_high", {31'd0, bus.busy}, 32'd1);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("t2_busy_dropped", {31'd0, bus.busy}, 32'd0);
        idle(50);

        // 3: bad stop bit, held break, then recovery
        send_frame(8'h55, 100, 1'b0, 1'b0);
        repeat (1000) @(negedge clk);
        chk("t3_busy_in_break", {31'd0, bus.busy}, 32'd1);
        idle(200);
        chk("t3_idle_after_break", {31'd0, bus.busy}, 32'd0);
        send_frame(8'h0F, 100, 1'b1, 1'b0);
        idle(60);
        chk("t3_data", {24'd0, bus.data}, 32'h0F);

        // 4: back-to-back frames with a single stop bit
        send_frame(8'hF0, 100, 1'b1, 1'b0);
        send_frame(8'h00, 100, 1'b1, 1'b0);
        idle(200);
        chk("t4_data", {24'd0, bus.data}, 32'h00);

        // 5: reset pulse during data bits of 0xA5 drops the frame
        clks_per_bit = 100;
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy_after_rst", {31'd0, bus.busy}, 32'd0);
        chk("t5_data_after_rst", {24'd0, bus.data}, 32'h00);
        idle(1200);
        send_frame(8'hA5, 100, 1'b1, 1'b0);
        idle(60);
        chk("t5_data", {24'd0, bus.data}, 32'hA5);

        // 6: period below minimum is clamped
        send_frame(8'h3C, 2, 1'b1, 1'b0);
        idle(20);
        chk("t6_data", {24'd0, bus.data}, 32'h3C);

        // random frames: periods incl. clamped, bad stops, mid-frame config changes, back-to-back
        for (int n = 0; n < 40; n++) begin
            int  cfg;
            int  bt;
            bit  ok;
            cfg = $urandom_range(1, 40);
            bt  = (cfg < 4) ? 4 : cfg;
            ok  = ($urandom_range(0, 5) != 0);
            send_frame(8'($urandom_range(0, 255)), cfg, ok, 1'($urandom_range(0, 1)));
            if (!ok)                            idle(bt + $urandom_range(0, bt));
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3 * bt));
        end

        idle(600);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
